strobed_alu_accum: RTL and testbench



---
 rtl/strobed_alu_accum.sv | 67 ++++++
 tb/tb_strobed_alu_accum.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/strobed_alu_accum.sv
// strobed_alu_accum: strobe-gated add/subtract/accumulate unit with optional saturation
// Ports: clk, rst_n (async, active-low); en freezes the block when 0;
//   div_ratio sets one strobe every div_ratio+1 enabled cycles; mode 00 add, 01 sub,
//   10 accumulate a, 11 clear; sat_en selects saturate over wrap; a, b unsigned operands;
//   result registered WIDTH+1 bits; out_valid pulses after each strobe;
//   overflow flags the last strobed op; ovf_sticky holds until clear or reset.
module strobed_alu_accum #(
  parameter int WIDTH = 7,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic [1:0]       mode,
  input  logic             sat_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   result,
  output logic             out_valid,
  output logic             overflow,
  output logic             ovf_sticky
);
  logic [DIV_W-1:0] cnt;
  logic [WIDTH:0]   acc;
  logic             tick;
  logic [WIDTH:0]   add_r;
  logic [WIDTH:0]   sub_r;
  logic             borrow;
  logic [WIDTH+1:0] acc_sum;
  logic             carry;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH:0]   nxt_res;
  logic             nxt_ovf;
  always_comb begin
    tick    = en && (cnt >= div_ratio);
    add_r   = {1'b0, a} + {1'b0, b};
    sub_r   = {1'b0, a} - {1'b0, b};
    borrow  = a < b;
    acc_sum = {1'b0, acc} + {2'b0, a};
    carry   = acc_sum[WIDTH+1];
    acc_nxt = (carry && sat_en) ? '1 : acc_sum[WIDTH:0];
    nxt_res = mode == 2'b00 ? add_r :
              mode == 2'b01 ? ((borrow && sat_en) ? '0 : sub_r) :
              mode == 2'b10 ? acc_nxt : '0;
    nxt_ovf = mode == 2'b01 ? borrow : mode == 2'b10 ? carry : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      acc        <= '0;
      result     <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      out_valid <= tick;
      if (en) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        result     <= nxt_res;
        overflow   <= nxt_ovf;
        acc        <= mode == 2'b10 ? acc_nxt : mode == 2'b11 ? '0 : acc;
        ovf_sticky <= mode == 2'b11 ? 1'b0 : (ovf_sticky | nxt_ovf);
      end
    end
  end
endmodule

// File: tb/tb_strobed_alu_accum.sv
// tb_strobed_alu_accum: directed and random checks against an arithmetic reference model
module tb_strobed_alu_accum;
  localparam int W = 7;
  localparam int DW = 4;
  localparam int TOP = 1 << (W + 1);
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] div_ratio = '0;
  logic [1:0]    mode = 2'b00;
  logic          sat_en = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W:0]    result;
  logic          out_valid;
  logic          overflow;
  logic          ovf_sticky;
  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt, m_acc, m_res, m_valid, m_ovf, m_sticky;
  strobed_alu_accum #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_ratio(div_ratio), .mode(mode),
    .sat_en(sat_en), .a(a), .b(b), .result(result), .out_valid(out_valid),
    .overflow(overflow), .ovf_sticky(ovf_sticky)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_cnt = 0; m_acc = 0; m_res = 0; m_valid = 0; m_ovf = 0; m_sticky = 0;
  endtask
  task automatic model_edge();
    int s;
    if (!en) begin
      m_valid = 0;
      return;
    end
    m_valid = (m_cnt >= int'(div_ratio)) ? 1 : 0;
    m_cnt = m_valid ? 0 : m_cnt + 1;
    if (!m_valid) return;
    case (mode)
      2'b00: begin m_res = int'(a) + int'(b); m_ovf = 0; end
      2'b01: begin
        m_ovf = (a < b) ? 1 : 0;
        m_res = !m_ovf ? int'(a) - int'(b) : (sat_en ? 0 : int'(a) - int'(b) + TOP);
      end
      2'b10: begin
        s = m_acc + int'(a);
        m_ovf = (s >= TOP) ? 1 : 0;
        m_acc = !m_ovf ? s : (sat_en ? TOP - 1 : s - TOP);
        m_res = m_acc;
      end
      default: begin m_acc = 0; m_res = 0; m_ovf = 0; m_sticky = 0; end
    endcase
    if (m_ovf) m_sticky = 1;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("result", result, m_res);
    chk("out_valid", out_valid, m_valid);
    chk("overflow", overflow, m_ovf);
    chk("ovf_sticky", ovf_sticky, m_sticky);
  endtask
  task automatic op(input logic [1:0] m, input logic s, input int av, input int bv);
    mode = m; sat_en = s; a = W'(av); b = W'(bv);
    step();
  endtask
  initial begin
    int guard;
    model_reset();
    #12;
    chk("rst_result", result, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sticky", ovf_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; div_ratio = 4'd1;
    op(2'b00, 0, 100, 27);
    chk("add_wait", out_valid, 0);
    step();
    chk("add127", result, 127);
    chk("add127_v", out_valid, 1);
    op(2'b00, 0, 127, 127);
    step();
    chk("add254", result, 254);
    div_ratio = 4'd0;
    op(2'b01, 0, 5, 9);
    chk("sub_wrap", result, 252);
    chk("sub_wrap_ovf", overflow, 1);
    chk("sub_wrap_stk", ovf_sticky, 1);
    op(2'b01, 1, 5, 9);
    chk("sub_sat", result, 0);
    op(2'b01, 0, 9, 5);
    chk("sub_ok", result, 4);
    chk("sub_ok_ovf", overflow, 0);
    chk("sub_ok_stk", ovf_sticky, 1);
    op(2'b11, 0, 0, 0);
    chk("clr_stk", ovf_sticky, 0);
    op(2'b10, 0, 100, 0); chk("acc100", result, 100);
    op(2'b10, 0, 100, 0); chk("acc200", result, 200);
    op(2'b10, 0, 100, 0); chk("acc44", result, 44); chk("acc44_ovf", overflow, 1);
    op(2'b11, 0, 0, 0);
    op(2'b10, 1, 100, 0); chk("sacc100", result, 100);
    op(2'b10, 1, 100, 0); chk("sacc200", result, 200);
    op(2'b10, 1, 100, 0); chk("sacc255a", result, 255); chk("sacc_ovf_a", overflow, 1);
    op(2'b10, 1, 100, 0); chk("sacc255b", result, 255); chk("sacc_ovf_b", overflow, 1);
    op(2'b11, 1, 0, 0);
    chk("clr_res", result, 0);
    chk("clr_stk2", ovf_sticky, 0);
    mode = 2'b00; a = 7'd3; b = 7'd4;
    div_ratio = 4'd15;
    for (int i = 0; i < 40; i++) step();
    guard = 0;
    while (!out_valid && guard < 20) begin step(); guard++; end
    chk("div15_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) step();
    div_ratio = 4'd2;
    step();
    chk("div_drop", out_valid, 1);
    step(); step();
    chk("div3_gap", out_valid, 0);
    step();
    chk("div3_tick", out_valid, 1);
    div_ratio = 4'd5;
    step(); step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    en = 1'b1;
    for (int i = 0; i < 8; i++) step();
    div_ratio = 4'd0; mode = 2'b10; a = 7'd60; sat_en = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_result", result, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_stk", ovf_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1; div_ratio = 4'd3; a = 7'd10;
    step(); step(); step();
    chk("arst_wait", out_valid, 0);
    step();
    chk("arst_first", out_valid, 1);
    chk("arst_acc", result, 10);
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) div_ratio = ($urandom_range(0, 7) == 0) ? 4'd15 : DW'($urandom_range(0, 3));
      mode = 2'($urandom);
      if ($urandom_range(0, 3) != 0 && mode == 2'b11) mode = 2'b10;
      sat_en = 1'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
